// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Central stall/flush sequencer for the six-stage RV32E pipeline
//   (IF, ID, EX, MEMPREP, MEMEX, WB).
//   - Detects load-use hazards against loads sitting in EX or MEMPREP.
//     Load data is forwarded from MEMEX, so one bubble is inserted per cycle
//     until the load reaches MEMEX.
//   - Sequences multi-cycle data-memory accesses launched from MEMPREP,
//     aborting an access after MEM_TIMEOUT busy cycles without mem_ready.
//   - Issues a one-shot flush/redirect for a taken branch resolved in EX.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   rs1_ID, rs2_ID           ID-stage source registers
//   uses_rs1_ID, uses_rs2_ID ID-stage instruction actually reads rs1 / rs2
//   rd_EX, mem_read_EX       destination and load flag of the EX instruction
//   rd_MEMPREP,
//   mem_read_MEMPREP         destination and load flag of the MEMPREP instruction
//   mem_req_MEMPREP          MEMPREP instruction needs the data memory
//   mem_ready                data memory completes the access this cycle
//   branch_taken_EX          EX resolved a taken branch/jump
//   stall_*                  hold enables for the pipeline registers
//   invalid_*                bubble markers for instructions leaving a stage
//   pc_redirect              PC loads the branch target this cycle
//   mem_start                one-cycle pulse launching a memory access
//   mem_busy                 memory sequencer is waiting on mem_ready
//   mem_fault                sticky timeout flag, cleared only by rst

module pipeline_hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rs1_ID,
    input  logic [3:0] rs2_ID,
    input  logic       uses_rs1_ID,
    input  logic       uses_rs2_ID,
    input  logic [3:0] rd_EX,
    input  logic       mem_read_EX,
    input  logic [3:0] rd_MEMPREP,
    input  logic       mem_read_MEMPREP,
    input  logic       mem_req_MEMPREP,
    input  logic       mem_ready,
    input  logic       branch_taken_EX,
    output logic       stall_IF,
    output logic       stall_ID,
    output logic       stall_EX,
    output logic       stall_MEMPREP,
    output logic       invalid_IF,
    output logic       invalid_ID,
    output logic       invalid_MEMPREP,
    output logic       pc_redirect,
    output logic       mem_start,
    output logic       mem_busy,
    output logic       mem_fault
);

    localparam logic [15:0] TimeoutCnt = 16'(MEM_TIMEOUT);

    typedef enum logic [0:0] {StIdle, StBusy} mem_state_e;

    mem_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;

    logic        mem_stall;
    logic        mem_timeout;
    logic        ex_hit;
    logic        mp_hit;
    logic        load_use;
    logic        branch;

    // x0 is hard-wired zero, so a write to it can never create a dependency.
    assign ex_hit = mem_read_EX && (rd_EX != 4'd0) &&
                    ((uses_rs1_ID && (rs1_ID == rd_EX)) ||
                     (uses_rs2_ID && (rs2_ID == rd_EX)));
    assign mp_hit = mem_read_MEMPREP && (rd_MEMPREP != 4'd0) &&
                    ((uses_rs1_ID && (rs1_ID == rd_MEMPREP)) ||
                     (uses_rs2_ID && (rs2_ID == rd_MEMPREP)));
    assign load_use = ex_hit || mp_hit;

    // mem_ready wins over the timeout when both land in the same cycle.
    assign mem_timeout = (state_q == StBusy) && !mem_ready && (cnt_q == TimeoutCnt);
    assign mem_stall   = ((state_q == StIdle) && mem_req_MEMPREP && !mem_ready) ||
                         ((state_q == StBusy) && !mem_ready && (cnt_q != TimeoutCnt));

    // A branch held in EX by a memory stall flushes in the first free cycle.
    assign branch = branch_taken_EX && !mem_stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (mem_req_MEMPREP && !mem_ready) begin
                    state_d = StBusy;
                    cnt_d   = 16'd1;
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    state_d = StIdle;
                    cnt_d   = 16'd0;
                end else if (mem_timeout) begin
                    state_d = StIdle;
                    cnt_d   = 16'd0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Reset is synchronous, so outputs are forced here while rst is high
    // rather than waiting for the registers to clear on the next edge.
    always_comb begin
        stall_IF        = 1'b0;
        stall_ID        = 1'b0;
        stall_EX        = 1'b0;
        stall_MEMPREP   = 1'b0;
        invalid_IF      = 1'b1;
        invalid_ID      = 1'b1;
        invalid_MEMPREP = 1'b1;
        pc_redirect     = 1'b0;
        mem_start       = 1'b0;
        mem_busy        = 1'b0;
        mem_fault       = 1'b0;
        if (!rst) begin
            // Branch flushes the dependent ID instruction, so it cancels load_use.
            stall_IF        = mem_stall || (load_use && !branch_taken_EX);
            stall_ID        = mem_stall || (load_use && !branch_taken_EX);
            stall_EX        = mem_stall;
            stall_MEMPREP   = mem_stall;
            invalid_IF      = branch;
            invalid_ID      = !mem_stall && (branch_taken_EX || load_use);
            invalid_MEMPREP = mem_timeout;
            pc_redirect     = branch;
            mem_start       = (state_q == StIdle) && mem_req_MEMPREP;
            mem_busy        = (state_q == StBusy);
            mem_fault       = fault_q;
        end
    end

endmodule
